// File: rtl/hist_eq_stream_if.sv
// Pixel stream bundle for hist_eq_stream: input pixel port, output pixel port, control and status.
// Valid/ready: a beat transfers on a rising clock edge where valid and ready are both high.
// The sender holds data stable and keeps valid high until that edge.
// o_dbg_state encoding: 0 IDLE, 1 CLEAR, 2 HIST, 3 RDMIN, 4 DIV, 5 SCAN, 6 MAP, 7 DONE.
interface hist_eq_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_start;
  logic                  i_bypass;
  logic [DATA_WIDTH-1:0] i_pixel;
  logic                  i_pixel_valid;
  logic                  o_pixel_ready;
  logic                  o_rd_image;
  logic [DATA_WIDTH-1:0] o_pixel;
  logic                  o_pixel_valid;
  logic                  i_pixel_ready;
  logic                  o_pixel_last;
  logic                  o_busy;
  logic                  o_done;
  logic [2:0]            o_dbg_state;

  modport slave (
    input  i_start, i_bypass, i_pixel, i_pixel_valid, i_pixel_ready,
    output o_pixel_ready, o_rd_image, o_pixel, o_pixel_valid, o_pixel_last,
           o_busy, o_done, o_dbg_state
  );

  modport master (
    output i_start, i_bypass, i_pixel, i_pixel_valid, i_pixel_ready,
    input  o_pixel_ready, o_rd_image, o_pixel, o_pixel_valid, o_pixel_last,
           o_busy, o_done, o_dbg_state
  );
endinterface

// File: rtl/hist_eq_stream.sv
// Frame histogram equalizer: pass 1 builds a RAM histogram, the CDF is scanned into a LUT,
// pass 2 re-reads the frame and streams remapped pixels with output backpressure.
module hist_eq_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FRAC_BITS  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  hist_eq_stream_if.slave   bus
);
  localparam int L      = 1 << DATA_WIDTH;
  localparam int N      = IMG_W * IMG_H;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int RCP_W  = DATA_WIDTH + FRAC_BITS;
  localparam int PROD_W = CNT_W + RCP_W;
  localparam int DIVC_W = $clog2(RCP_W + 1);

  localparam logic [CNT_W-1:0]      N_C      = CNT_W'(N);
  localparam logic [RCP_W-1:0]      DIVIDEND = RCP_W'(L - 1) << FRAC_BITS;
  localparam logic [DATA_WIDTH-1:0] LMAX     = '1;
  localparam logic [PROD_W:0]       RND      = (PROD_W + 1)'(1) << (FRAC_BITS - 1);
  localparam logic [PROD_W:0]       LMAX_W   = (PROD_W + 1)'(L - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_HIST  = 3'd2,
    S_RDMIN = 3'd3,
    S_DIV   = 3'd4,
    S_SCAN  = 3'd5,
    S_MAP   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t                state_q;
  logic                  bypass_q, ident_q;
  logic [CNT_W-1:0]      in_cnt_q;
  logic [DATA_WIDTH-1:0] pmin_q, clr_cnt_q;
  logic                  s1_v_q, s2_v_q;
  logic [DATA_WIDTH-1:0] s1_p_q, s2_p_q;
  logic [CNT_W-1:0]      s2_cnt_q;
  logic [CNT_W-1:0]      cdf_min_q, rem_q, cdf_q;
  logic [RCP_W-1:0]      dvd_q, recip_q;
  logic [DIVC_W-1:0]     div_cnt_q;
  logic [DATA_WIDTH:0]   scan_cnt_q;
  logic                  sb_v_q, sc_v_q;
  logic [DATA_WIDTH-1:0] sb_idx_q, sc_idx_q;
  logic [PROD_W-1:0]     prod_q;
  logic                  m1_v_q, m1_last_q;
  logic [DATA_WIDTH-1:0] m1_pix_q;
  logic [DATA_WIDTH-1:0] opix_q;
  logic                  ovalid_q, olast_q;

  logic [CNT_W-1:0]      hist_mem [L];
  logic [DATA_WIDTH-1:0] lut_mem  [L];
  logic [CNT_W-1:0]      hist_rd_q;
  logic [DATA_WIDTH-1:0] lut_rd_q;

  logic                  in_full, stall, pixel_ready, xfer;
  logic [CNT_W-1:0]      hist_base, hist_inc, hist_wdata;
  logic                  hist_we;
  logic [DATA_WIDTH-1:0] hist_waddr, hist_raddr;
  logic [CNT_W-1:0]      d_val, r_sub_lo, cdf_next, cdf_diff;
  logic [CNT_W:0]        r_shift;
  logic                  sub_ok;
  logic [PROD_W-1:0]     prod_d;
  logic [PROD_W:0]       rounded;
  logic [DATA_WIDTH-1:0] lut_val;

  assign in_full     = (in_cnt_q == N_C);
  assign stall       = ovalid_q & ~bus.i_pixel_ready;
  assign pixel_ready = ((state_q == S_HIST) & ~in_full) |
                       ((state_q == S_MAP) & ~stall & ~in_full);
  assign xfer        = pixel_ready & bus.i_pixel_valid;

  // Histogram RMW: the bin written last cycle is not yet visible to a read issued then,
  // so the stage-2 copy overrides the RAM data on an address match.
  always_comb begin
    hist_base  = (s2_v_q && (s2_p_q == s1_p_q)) ? s2_cnt_q : hist_rd_q;
    hist_inc   = hist_base + CNT_W'(1);
    hist_we    = 1'b0;
    hist_waddr = s1_p_q;
    hist_wdata = hist_inc;
    hist_raddr = bus.i_pixel;
    if (state_q == S_CLEAR) begin
      hist_we    = 1'b1;
      hist_waddr = clr_cnt_q;
      hist_wdata = '0;
    end else if ((state_q == S_HIST) && s1_v_q) begin
      hist_we = 1'b1;
    end
    if (state_q == S_SCAN) begin
      hist_raddr = scan_cnt_q[DATA_WIDTH-1:0];
    end else if ((state_q == S_HIST) && in_full) begin
      hist_raddr = pmin_q;
    end
  end

  // One restoring-divider step per cycle; the quotient bits shift into dvd_q.
  assign d_val    = N_C - cdf_min_q;
  assign r_shift  = {rem_q, dvd_q[RCP_W-1]};
  assign sub_ok   = (r_shift >= {1'b0, d_val});
  assign r_sub_lo = r_shift[CNT_W-1:0] - d_val;

  assign cdf_next = cdf_q + hist_rd_q;
  assign cdf_diff = (cdf_next > cdf_min_q) ? (cdf_next - cdf_min_q) : '0;
  assign prod_d   = PROD_W'(cdf_diff) * PROD_W'(recip_q);
  assign rounded  = ({1'b0, prod_q} + RND) >> FRAC_BITS;
  assign lut_val  = (rounded > LMAX_W) ? LMAX : rounded[DATA_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (hist_we) hist_mem[hist_waddr] <= hist_wdata;
    hist_rd_q <= hist_mem[hist_raddr];
  end

  always_ff @(posedge i_clk) begin
    if (sc_v_q) lut_mem[sc_idx_q] <= ident_q ? sc_idx_q : lut_val;
    if ((state_q == S_MAP) && !stall) lut_rd_q <= lut_mem[bus.i_pixel];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      bypass_q  <= 1'b0;
      ident_q   <= 1'b0;
      in_cnt_q  <= '0;
      pmin_q    <= '0;
      clr_cnt_q <= '0;
      s1_v_q    <= 1'b0;
      s1_p_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_p_q    <= '0;
      s2_cnt_q  <= '0;
      cdf_min_q <= '0;
      rem_q     <= '0;
      cdf_q     <= '0;
      dvd_q     <= '0;
      recip_q   <= '0;
      div_cnt_q <= '0;
      scan_cnt_q <= '0;
      sb_v_q    <= 1'b0;
      sb_idx_q  <= '0;
      sc_v_q    <= 1'b0;
      sc_idx_q  <= '0;
      prod_q    <= '0;
      m1_v_q    <= 1'b0;
      m1_last_q <= 1'b0;
      m1_pix_q  <= '0;
      opix_q    <= '0;
      ovalid_q  <= 1'b0;
      olast_q   <= 1'b0;
    end else begin
      s1_v_q   <= (state_q == S_HIST) && xfer;
      s1_p_q   <= bus.i_pixel;
      s2_v_q   <= s1_v_q;
      s2_p_q   <= s1_p_q;
      s2_cnt_q <= hist_inc;

      sb_v_q   <= (state_q == S_SCAN) && !scan_cnt_q[DATA_WIDTH];
      sb_idx_q <= scan_cnt_q[DATA_WIDTH-1:0];
      sc_v_q   <= sb_v_q;
      sc_idx_q <= sb_idx_q;
      if (sb_v_q) begin
        cdf_q  <= cdf_next;
        prod_q <= prod_d;
      end

      // Map pipe: LUT read, then output register; frozen as a whole during a stall.
      if ((state_q == S_MAP) && !stall) begin
        m1_v_q    <= xfer;
        m1_pix_q  <= bus.i_pixel;
        m1_last_q <= xfer && (in_cnt_q == N_C - CNT_W'(1));
        ovalid_q  <= m1_v_q;
        opix_q    <= bypass_q ? m1_pix_q : lut_rd_q;
        olast_q   <= m1_v_q && m1_last_q;
      end

      if (xfer) in_cnt_q <= in_cnt_q + CNT_W'(1);

      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            bypass_q  <= bus.i_bypass;
            ident_q   <= 1'b0;
            in_cnt_q  <= '0;
            clr_cnt_q <= '0;
            pmin_q    <= LMAX;
            state_q   <= bus.i_bypass ? S_MAP : S_CLEAR;
          end
        end
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + DATA_WIDTH'(1);
          if (clr_cnt_q == LMAX) state_q <= S_HIST;
        end
        S_HIST: begin
          if (xfer && (bus.i_pixel < pmin_q)) pmin_q <= bus.i_pixel;
          if (in_full && !s1_v_q) state_q <= S_RDMIN;
        end
        S_RDMIN: begin
          cdf_min_q <= hist_rd_q;
          rem_q     <= '0;
          dvd_q     <= DIVIDEND;
          div_cnt_q <= '0;
          state_q   <= S_DIV;
        end
        S_DIV: begin
          cdf_q      <= '0;
          scan_cnt_q <= '0;
          if (d_val == '0) begin
            ident_q <= 1'b1;
            state_q <= S_SCAN;
          end else begin
            rem_q     <= sub_ok ? r_sub_lo : r_shift[CNT_W-1:0];
            dvd_q     <= {dvd_q[RCP_W-2:0], sub_ok};
            div_cnt_q <= div_cnt_q + DIVC_W'(1);
            if (div_cnt_q == DIVC_W'(RCP_W - 1)) begin
              recip_q <= {dvd_q[RCP_W-2:0], sub_ok};
              state_q <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (!scan_cnt_q[DATA_WIDTH]) scan_cnt_q <= scan_cnt_q + (DATA_WIDTH + 1)'(1);
          if (sc_v_q && (sc_idx_q == LMAX)) begin
            in_cnt_q <= '0;
            state_q  <= S_MAP;
          end
        end
        S_MAP: begin
          if (ovalid_q && bus.i_pixel_ready && olast_q) state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_pixel_ready = pixel_ready;
  assign bus.o_rd_image    = (state_q == S_HIST) || (state_q == S_MAP);
  assign bus.o_pixel       = opix_q;
  assign bus.o_pixel_valid = ovalid_q;
  assign bus.o_pixel_last  = olast_q;
  assign bus.o_busy        = (state_q != S_IDLE);
  assign bus.o_done        = (state_q == S_DONE);
  assign bus.o_dbg_state   = state_q;
endmodule
